// File: rtl/updown_counter_prog.sv
// Programmable up/down counter driven by an internal prescaler tick.
// Supports wrap, saturate, bounce and one-shot modes, parallel load and a terminal-count pulse.
module updown_counter_prog #(
    parameter int W   = 8,
    parameter int DIV = 4
) (
    input  logic         Clk,
    input  logic         RST,
    input  logic         UD,
    input  logic         SS,
    input  logic         Load,
    input  logic [W-1:0] LoadVal,
    input  logic [W-1:0] MaxVal,
    input  logic [1:0]   Mode,
    output logic [W-1:0] Count_Out,
    output logic         Tc,
    output logic         Tick_Out,
    output logic         Dir_Out,
    output logic         Done
);

    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         tc;
        logic         dir;
        logic         bdir;
        logic         done;
    } step_t;

    // Outcome of one count step; the up path compares before incrementing so it never runs past mx.
    function automatic step_t step_next(
        input logic [1:0]   mode,
        input logic         ud,
        input logic [W-1:0] cnt,
        input logic [W-1:0] mx,
        input logic         bdir,
        input logic         dir,
        input logic         done
    );
        step_t        r;
        logic         at_top;
        logic         at_bot;
        logic         ed;
        logic [W-1:0] inc;
        logic [W-1:0] dec;
        r.cnt  = cnt;
        r.tc   = 1'b0;
        r.dir  = dir;
        r.bdir = bdir;
        r.done = done;
        at_top = (cnt >= mx);
        at_bot = (cnt == '0);
        inc    = cnt + W'(1);
        dec    = cnt - W'(1);
        ed     = bdir;
        case (mode)
            2'b00: begin
                r.dir = ud;
                if (!ud) begin
                    if (at_top) begin
                        r.cnt = '0;
                        r.tc  = 1'b1;
                    end else begin
                        r.cnt = inc;
                    end
                end else begin
                    if (at_bot) begin
                        r.cnt = mx;
                        r.tc  = 1'b1;
                    end else begin
                        r.cnt = dec;
                    end
                end
            end
            2'b01: begin
                r.dir = ud;
                if (!ud) begin
                    if (at_top) begin
                        r.cnt = mx;
                    end else begin
                        r.cnt = inc;
                        r.tc  = (inc == mx);
                    end
                end else if (!at_bot) begin
                    r.cnt = dec;
                    r.tc  = (dec == '0);
                end
            end
            2'b10: begin
                if (mx == '0) begin
                    r.cnt  = '0;
                    r.tc   = 1'b1;
                    r.dir  = bdir;
                    r.bdir = ~bdir;
                end else begin
                    // A stale direction pointing past an end is turned around before stepping.
                    if (!ed && at_top) begin
                        ed = 1'b1;
                    end else if (ed && at_bot) begin
                        ed = 1'b0;
                    end
                    r.dir = ed;
                    if (!ed) begin
                        r.cnt  = inc;
                        r.tc   = (inc == mx);
                        r.bdir = (inc == mx);
                    end else begin
                        r.cnt  = (cnt > mx) ? (mx - W'(1)) : dec;
                        r.tc   = (r.cnt == '0);
                        r.bdir = (r.cnt != '0);
                    end
                end
            end
            default: begin
                if (!done) begin
                    r.dir = ud;
                    if (!ud) begin
                        if (at_top) begin
                            r.cnt  = mx;
                            r.tc   = 1'b1;
                            r.done = 1'b1;
                        end else begin
                            r.cnt  = inc;
                            r.tc   = (inc == mx);
                            r.done = (inc == mx);
                        end
                    end else begin
                        if (at_bot) begin
                            r.tc   = 1'b1;
                            r.done = 1'b1;
                        end else begin
                            r.cnt  = dec;
                            r.tc   = (dec == '0);
                            r.done = (dec == '0);
                        end
                    end
                end
            end
        endcase
        return r;
    endfunction

    logic [W-1:0]  cnt_q,  cnt_d;
    logic [PW-1:0] pre_q,  pre_d;
    logic          tc_q,   tc_d;
    logic          tick_q, tick_d;
    logic          dir_q,  dir_d;
    logic          bdir_q, bdir_d;
    logic          done_q, done_d;
    logic          tick;
    step_t         nxt;

    always_comb begin
        tick   = (pre_q == PRE_LAST);
        nxt    = step_next(Mode, UD, cnt_q, MaxVal, bdir_q, dir_q, done_q);
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        tc_d   = 1'b0;
        tick_d = tick;
        dir_d  = dir_q;
        bdir_d = bdir_q;
        done_d = done_q;
        if (Load) begin
            cnt_d  = (LoadVal > MaxVal) ? MaxVal : LoadVal;
            pre_d  = '0;
            done_d = 1'b0;
            bdir_d = UD;
        end else if (SS) begin
            pre_d = tick ? '0 : (pre_q + PW'(1));
            if (tick) begin
                cnt_d  = nxt.cnt;
                tc_d   = nxt.tc;
                dir_d  = nxt.dir;
                bdir_d = nxt.bdir;
                done_d = nxt.done;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (RST) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            tc_q   <= 1'b0;
            tick_q <= 1'b0;
            dir_q  <= 1'b0;
            bdir_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            tc_q   <= tc_d;
            tick_q <= tick_d;
            dir_q  <= dir_d;
            bdir_q <= bdir_d;
            done_q <= done_d;
        end
    end

    assign Count_Out = cnt_q;
    assign Tc        = tc_q;
    assign Tick_Out  = tick_q;
    assign Dir_Out   = dir_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_updown_counter_prog.sv
// Bench for updown_counter_prog (W=8, DIV=4): vector table of loads and steps, scoreboard
// popped on each Tick_Out pulse, plus hand sequences for hold, reset priority and reset-vs-step.
module tb_updown_counter_prog;

    logic       Clk = 1'b0;
    logic       RST, UD, SS, Load;
    logic [7:0] LoadVal, MaxVal;
    logic [1:0] Mode;
    logic [7:0] Count_Out;
    logic       Tc, Tick_Out, Dir_Out, Done;

    updown_counter_prog #(.W(8), .DIV(4)) dut (
        .Clk(Clk), .RST(RST), .UD(UD), .SS(SS), .Load(Load), .LoadVal(LoadVal),
        .MaxVal(MaxVal), .Mode(Mode), .Count_Out(Count_Out), .Tc(Tc),
        .Tick_Out(Tick_Out), .Dir_Out(Dir_Out), .Done(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       ld;
        logic [1:0] mode;
        logic       ud;
        logic [7:0] mx;
        logic [7:0] lv;
        logic [7:0] cnt;
        logic       tc;
        logic       dir;
        logic       done;
    } vec_t;

    typedef struct {
        logic [7:0] cnt;
        logic       tc;
        logic       dir;
        logic       done;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic ld, input logic [1:0] m, input logic ud, input int mx,
                       input int lv, input int c, input logic tc, input logic dir, input logic dn);
        vt.push_back('{ld, m, ud, 8'(mx), 8'(lv), 8'(c), tc, dir, dn});
    endtask

    // Each Tick_Out pulse marks the cycle after a step edge, when the step's results are visible.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (Tick_Out) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_tick: got a step with no expected entry (t=%0t)", $time);
                end else begin
                    mon_e = sb.pop_front();
                    check("step_count", Count_Out, mon_e.cnt);
                    check("step_tc", Tc, mon_e.tc);
                    check("step_dir", Dir_Out, mon_e.dir);
                    check("step_done", Done, mon_e.done);
                end
            end else begin
                check("tc_idle", Tc, 0);
            end
        end
    end

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            Mode   = vt[i].mode;
            UD     = vt[i].ud;
            MaxVal = vt[i].mx;
            SS     = 1'b1;
            if (vt[i].ld) begin
                LoadVal = vt[i].lv;
                Load    = 1'b1;
                @(posedge Clk); #1;
                Load = 1'b0;
                check("load_count", Count_Out, vt[i].cnt);
                check("load_done", Done, vt[i].done);
                check("load_tc", Tc, 0);
            end else begin
                sb.push_back('{cnt: vt[i].cnt, tc: vt[i].tc, dir: vt[i].dir, done: vt[i].done});
                repeat (4) @(posedge Clk);
                #1;
            end
        end
    endtask

    initial begin
        //   ld mode ud  mx   lv  cnt tc dir done
        add(0, 2'd0, 0,   5,   0,   1, 0, 0, 0);
        add(0, 2'd0, 0,   5,   0,   2, 0, 0, 0);
        add(0, 2'd0, 0,   5,   0,   3, 0, 0, 0);
        add(0, 2'd0, 0,   5,   0,   4, 0, 0, 0);
        add(0, 2'd0, 0,   5,   0,   5, 0, 0, 0);
        add(0, 2'd0, 0,   5,   0,   0, 1, 0, 0);
        add(1, 2'd0, 1,   5,   1,   1, 0, 0, 0);
        add(0, 2'd0, 1,   5,   0,   0, 0, 1, 0);
        add(0, 2'd0, 1,   5,   0,   5, 1, 1, 0);
        add(0, 2'd0, 1,   5,   0,   4, 0, 1, 0);
        // saturate up then down
        add(1, 2'd1, 0,   3,   0,   0, 0, 0, 0);
        add(0, 2'd1, 0,   3,   0,   1, 0, 0, 0);
        add(0, 2'd1, 0,   3,   0,   2, 0, 0, 0);
        add(0, 2'd1, 0,   3,   0,   3, 1, 0, 0);
        add(0, 2'd1, 0,   3,   0,   3, 0, 0, 0);
        add(0, 2'd1, 0,   3,   0,   3, 0, 0, 0);
        add(0, 2'd1, 1,   3,   0,   2, 0, 1, 0);
        add(0, 2'd1, 1,   3,   0,   1, 0, 1, 0);
        add(0, 2'd1, 1,   3,   0,   0, 1, 1, 0);
        add(0, 2'd1, 1,   3,   0,   0, 0, 1, 0);
        // bounce, UD held at 1 on steps to show it is ignored
        add(1, 2'd2, 0,   3,   0,   0, 0, 0, 0);
        add(0, 2'd2, 1,   3,   0,   1, 0, 0, 0);
        add(0, 2'd2, 1,   3,   0,   2, 0, 0, 0);
        add(0, 2'd2, 1,   3,   0,   3, 1, 0, 0);
        add(0, 2'd2, 1,   3,   0,   2, 0, 1, 0);
        add(0, 2'd2, 1,   3,   0,   1, 0, 1, 0);
        add(0, 2'd2, 1,   3,   0,   0, 1, 1, 0);
        add(0, 2'd2, 1,   3,   0,   1, 0, 0, 0);
        add(1, 2'd2, 0,   0,   0,   0, 0, 0, 0);
        add(0, 2'd2, 1,   0,   0,   0, 1, 0, 0);
        add(0, 2'd2, 1,   0,   0,   0, 1, 1, 0);
        add(0, 2'd2, 1,   0,   0,   0, 1, 0, 0);
        // one-shot up, clamped reload, step at bound, one-shot down
        add(1, 2'd3, 0,   4,   0,   0, 0, 0, 0);
        add(0, 2'd3, 0,   4,   0,   1, 0, 0, 0);
        add(0, 2'd3, 0,   4,   0,   2, 0, 0, 0);
        add(0, 2'd3, 0,   4,   0,   3, 0, 0, 0);
        add(0, 2'd3, 0,   4,   0,   4, 1, 0, 1);
        add(0, 2'd3, 0,   4,   0,   4, 0, 0, 1);
        add(0, 2'd3, 0,   4,   0,   4, 0, 0, 1);
        add(1, 2'd3, 0,   4,   9,   4, 0, 0, 0);
        add(0, 2'd3, 0,   4,   0,   4, 1, 0, 1);
        add(1, 2'd3, 1,   4,   2,   2, 0, 0, 0);
        add(0, 2'd3, 1,   4,   0,   1, 0, 1, 0);
        add(0, 2'd3, 1,   4,   0,   0, 1, 1, 1);
        add(0, 2'd3, 1,   4,   0,   0, 0, 1, 1);
        // MaxVal lowered below the count, then full 8-bit wrap both ways
        add(1, 2'd0, 0, 200,  50,  50, 0, 0, 0);
        add(0, 2'd0, 0, 200,   0,  51, 0, 0, 0);
        add(0, 2'd0, 0,  10,   0,   0, 1, 0, 0);
        add(0, 2'd0, 0,  10,   0,   1, 0, 0, 0);
        add(1, 2'd0, 0, 255, 254, 254, 0, 0, 0);
        add(0, 2'd0, 0, 255,   0, 255, 0, 0, 0);
        add(0, 2'd0, 0, 255,   0,   0, 1, 0, 0);
        add(1, 2'd0, 1, 255,   0,   0, 0, 0, 0);
        add(0, 2'd0, 1, 255,   0, 255, 1, 1, 0);

        RST = 1'b1; UD = 1'b0; SS = 1'b1; Load = 1'b0;
        LoadVal = 8'd0; MaxVal = 8'd5; Mode = 2'd0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_count", Count_Out, 0);
        check("rst_tc", Tc, 0);
        check("rst_tick", Tick_Out, 0);
        check("rst_dir", Dir_Out, 0);
        check("rst_done", Done, 0);
        RST    = 1'b0;
        mon_en = 1'b1;

        run_range(0, 10);

        // hold mid-phase: count and prescaler freeze, step resumes two cycles after release
        repeat (2) @(posedge Clk);
        #1;
        SS = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge Clk); #1;
            check("hold_count", Count_Out, 4);
            check("hold_tick", Tick_Out, 0);
        end
        SS = 1'b1;
        sb.push_back('{cnt: 8'd3, tc: 1'b0, dir: 1'b1, done: 1'b0});
        @(posedge Clk); #1;
        check("resume_count", Count_Out, 4);
        @(posedge Clk); #1;

        run_range(10, vt.size());

        // reset beats a simultaneous load
        Mode = 2'd0; UD = 1'b0; MaxVal = 8'd255;
        RST = 1'b1; Load = 1'b1; LoadVal = 8'd7;
        @(posedge Clk); #1;
        RST = 1'b0; Load = 1'b0;
        check("rstload_count", Count_Out, 0);
        check("rstload_dir", Dir_Out, 0);
        check("rstload_done", Done, 0);
        check("rstload_tc", Tc, 0);

        // reset on the edge where a step would have happened
        repeat (3) @(posedge Clk);
        #1;
        RST = 1'b1;
        @(posedge Clk); #1;
        RST = 1'b0;
        check("rststep_count", Count_Out, 0);
        check("rststep_tick", Tick_Out, 0);
        repeat (2) @(posedge Clk);
        #1;
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
